// File: rtl/tia_horizontal_pkg.sv
// ---------------------------------------------------------------------------
// tia_horizontal_pkg
// Shared constants and helpers for the TIA horizontal timing section.
//   - Decode codes of the 6-bit LFSR horizontal counter.
//   - lfsr_shift: raw shift/feedback step, before the END/ERR wrap.
//   - LINE_TICKS: number of counter states visited in one line. It is
//     derived from the step function, so it always agrees with the counter.
// ---------------------------------------------------------------------------
package tia_horizontal_pkg;

  localparam logic [5:0] CNT_START = 6'b000000;  // line start, HBLANK on
  localparam logic [5:0] END       = 6'b010100;  // never held: wraps to start
  localparam logic [5:0] ERR       = 6'b111111;  // lock-up state, forced to start
  localparam logic [5:0] CNT_SHS   = 6'b011111;  // HSYNC on
  localparam logic [5:0] CNT_RHS   = 6'b110111;  // HSYNC off, burst on
  localparam logic [5:0] CNT_RCB   = 6'b111001;  // burst off
  localparam logic [5:0] CNT_RHB   = 6'b011101;  // HBLANK off (normal)
  localparam logic [5:0] CNT_LRHB  = 6'b110101;  // HBLANK off (late, after HMOVE)

  function automatic logic [5:0] lfsr_shift(input logic [5:0] count);
    return {count[4:0], ~(count[5] ^ count[4])};
  endfunction

  // Walk the counter from CNT_START until the step would produce END.
  function automatic int count_line_ticks();
    logic [5:0] c;
    int         n;
    logic       done;
    c    = CNT_START;
    n    = 0;
    done = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (!done) begin
        n    = n + 1;
        c    = lfsr_shift(c);
        done = (c == END);
      end
    end
    return n;
  endfunction

  localparam int LINE_TICKS = count_line_ticks();

endpackage

// File: rtl/tia_horizontal_timing_lfsr6_step.sv
// ---------------------------------------------------------------------------
// tia_lfsr6_step
// Combinational next-count for the 6-bit horizontal LFSR, including the
// end-of-line wrap: a step that would produce END, or a counter stuck in ERR,
// yields CNT_START instead.
// Ports:
//   count       in  6  current counter value
//   next_count  out 6  counter value after one tick
// ---------------------------------------------------------------------------
module tia_lfsr6_step
  import tia_horizontal_pkg::*;
(
  input  logic [5:0] count,
  output logic [5:0] next_count
);

  logic [5:0] shifted;

  always_comb begin
    shifted    = lfsr_shift(count);
    next_count = shifted;
    if ((count == ERR) || (shifted == END)) begin
      next_count = CNT_START;
    end
  end

endmodule

// File: rtl/tia_horizontal_timing.sv
// ---------------------------------------------------------------------------
// tia_horizontal_timing
// Horizontal line sequencer: owns the 6-bit LFSR horizontal count, decodes it
// into line timing flags and services the RSYNC / WSYNC / HMOVE strobes.
// All outputs are registered; flags change on the same clock that hcount
// takes the code that decodes them.
// Ports:
//   clk         in   1  system clock
//   reset       in   1  synchronous, active-high reset
//   tick        in   1  count enable, one cycle per horizontal phase
//   rsync       in   1  strobe: restart line on the next tick
//   wsync       in   1  strobe: hold CPU (rdy=0) until next line start
//   hmove       in   1  strobe: request late HBLANK release
//   hcount      out  6  current LFSR count
//   line_start  out  1  one-clock pulse when hcount enters 000000
//   hsync       out  1  horizontal sync
//   cburst      out  1  colour burst window
//   hblank      out  1  horizontal blank
//   rdy         out  1  CPU ready (0 = halted by WSYNC)
// Configuration:
//   TIA_HMOVE_LATE_HBLANK_EN  when defined, hmove delays the HBLANK release
//                             to CNT_LRHB for the current or next line.
//                             When undefined, hmove is ignored.
// ---------------------------------------------------------------------------
module tia_horizontal_timing
  import tia_horizontal_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       rsync,
  input  logic       wsync,
  input  logic       hmove,
  output logic [5:0] hcount,
  output logic       line_start,
  output logic       hsync,
  output logic       cburst,
  output logic       hblank,
  output logic       rdy
);

  logic [5:0] step_count;
  logic [5:0] next_count;
  logic       rsync_pend;
  logic       restart;
  logic       enter_start;
  logic       late_active;

  tia_lfsr6_step u_step (
    .count      (hcount),
    .next_count (step_count)
  );

  // A strobe arriving on a tick cycle restarts on that same tick; a restart
  // that coincides with the natural wrap still enters 000000 only once.
  assign restart     = rsync | rsync_pend;
  assign next_count  = restart ? CNT_START : step_count;
  assign enter_start = tick && (next_count == CNT_START);

  always_ff @(posedge clk) begin
    if (reset) begin
      rsync_pend <= 1'b0;
    end else if (tick) begin
      rsync_pend <= 1'b0;
    end else if (rsync) begin
      rsync_pend <= 1'b1;
    end
  end

`ifdef TIA_HMOVE_LATE_HBLANK_EN
  logic late_cur;
  logic late_next;
  logic release_now;

  assign late_active = late_cur;
  // The normal release decision is taken on the tick entering CNT_RHB; an
  // hmove from that cycle on belongs to the next line.
  assign release_now = tick && (next_count == CNT_RHB);

  always_ff @(posedge clk) begin
    if (reset) begin
      late_cur  <= 1'b0;
      late_next <= 1'b0;
    end else if (enter_start) begin
      late_cur  <= late_next | hmove;
      late_next <= 1'b0;
    end else if (hmove) begin
      if (hblank && !release_now) begin
        late_cur <= 1'b1;
      end else begin
        late_next <= 1'b1;
      end
    end
  end
`else
  logic unused_hmove;

  assign late_active  = 1'b0;
  assign unused_hmove = hmove;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      hcount     <= CNT_START;
      line_start <= 1'b0;
      hsync      <= 1'b0;
      cburst     <= 1'b0;
      hblank     <= 1'b1;
      rdy        <= 1'b1;
    end else begin
      line_start <= enter_start;

      // A new WSYNC wins over the release, so a strobe during the line-start
      // cycle holds the CPU for the whole following line.
      if (wsync) begin
        rdy <= 1'b0;
      end else if (enter_start) begin
        rdy <= 1'b1;
      end

      if (tick) begin
        hcount <= next_count;
        case (next_count)
          CNT_START: hblank <= 1'b1;
          CNT_SHS:   hsync  <= 1'b1;
          CNT_RHS: begin
            hsync  <= 1'b0;
            cburst <= 1'b1;
          end
          CNT_RCB:   cburst <= 1'b0;
          CNT_RHB: begin
            if (!late_active) begin
              hblank <= 1'b0;
            end
          end
          CNT_LRHB:  hblank <= 1'b0;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tia_horizontal_timing.sv
// ---------------------------------------------------------------------------
// tb_tia_horizontal_timing
// Directed bench for tia_horizontal_timing. A hand-written table covers the
// first part of a line after reset; the rest of each scenario is compared
// against a small reference: the counter step formula for hcount and the
// line index for the timing flags (HSYNC 5-8, burst 9-12, HBLANK until 17,
// or until 19 when a late release is in effect).
// ---------------------------------------------------------------------------
module tb_tia_horizontal_timing;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       rsync;
  logic       wsync;
  logic       hmove;
  logic [5:0] hcount;
  logic       line_start;
  logic       hsync;
  logic       cburst;
  logic       hblank;
  logic       rdy;

  int checks;
  int failures;

  logic [5:0] exp_h;
  int         exp_idx;
  logic       exp_ls;

  localparam int REL_NORM = 17;
`ifdef TIA_HMOVE_LATE_HBLANK_EN
  localparam int REL_LATE = 19;
`else
  localparam int REL_LATE = 17;
`endif

  typedef struct {
    logic       tick;
    logic       rsync;
    logic       wsync;
    logic       hmove;
    logic [5:0] hc;
    logic       ls;
    logic       hs;
    logic       cb;
    logic       hb;
    logic       rd;
  } vec_t;

  vec_t vecs[20];

  tia_horizontal_timing dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .rsync      (rsync),
    .wsync      (wsync),
    .hmove      (hmove),
    .hcount     (hcount),
    .line_start (line_start),
    .hsync      (hsync),
    .cburst     (cburst),
    .hblank     (hblank),
    .rdy        (rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic ws, input logic [5:0] hc, input logic hs,
                              input logic cb, input logic hb, input logic rd);
    vec_t v;
    v.tick = 1'b1; v.rsync = 1'b0; v.wsync = ws; v.hmove = 1'b0;
    v.hc = hc; v.ls = 1'b0; v.hs = hs; v.cb = cb; v.hb = hb; v.rd = rd;
    return v;
  endfunction

  function automatic logic [5:0] ref_step(input logic [5:0] h);
    logic [5:0] n;
    if (h == 6'b111111) return 6'b000000;
    n = {h[4:0], ~(h[5] ^ h[4])};
    if (n == 6'b010100) return 6'b000000;
    return n;
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic check6(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Apply one clock of inputs; strobes are cleared after the edge and
  // outputs are sampled 1 time unit after it.
  task automatic cyc(input logic t, input logic rs, input logic ws, input logic hm);
    tick = t; rsync = rs; wsync = ws; hmove = hm;
    @(posedge clk);
    #1;
    rsync = 1'b0; wsync = 1'b0; hmove = 1'b0;
  endtask

  task automatic model_adv(input logic restart);
    exp_h   = restart ? 6'b000000 : ref_step(exp_h);
    exp_idx = (exp_h == 6'b000000) ? 0 : exp_idx + 1;
    exp_ls  = (exp_h == 6'b000000);
  endtask

  task automatic model_hold();
    exp_ls = 1'b0;
  endtask

  task automatic check_model(input int rel);
    check6($sformatf("hcount@%0d", exp_idx), hcount, exp_h);
    check1($sformatf("line_start@%0d", exp_idx), line_start, exp_ls);
    check1($sformatf("hsync@%0d", exp_idx), hsync, (exp_idx >= 5) && (exp_idx <= 8));
    check1($sformatf("cburst@%0d", exp_idx), cburst, (exp_idx >= 9) && (exp_idx <= 12));
    check1($sformatf("hblank@%0d", exp_idx), hblank, exp_idx < rel);
  endtask

  task automatic run(input int n, input int rel);
    for (int k = 0; k < n; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      model_adv(1'b0);
      check_model(rel);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check6({tag, "_hcount"}, hcount, 6'b000000);
    check1({tag, "_line_start"}, line_start, 1'b0);
    check1({tag, "_hsync"}, hsync, 1'b0);
    check1({tag, "_cburst"}, cburst, 1'b0);
    check1({tag, "_hblank"}, hblank, 1'b1);
    check1({tag, "_rdy"}, rdy, 1'b1);
  endtask

  initial begin
    int ls_count;
    checks   = 0;
    failures = 0;
    reset = 1'b1; tick = 1'b0; rsync = 1'b0; wsync = 1'b0; hmove = 1'b0;

    // Ticks 1..20 after reset; wsync strobed in the cycle at index 17.
    vecs[0]  = mk(1'b0, 6'b000001, 1'b0, 1'b0, 1'b1, 1'b1);
    vecs[1]  = mk(1'b0, 6'b000011, 1'b0, 1'b0, 1'b1, 1'b1);
    vecs[2]  = mk(1'b0, 6'b000111, 1'b0, 1'b0, 1'b1, 1'b1);
    vecs[3]  = mk(1'b0, 6'b001111, 1'b0, 1'b0, 1'b1, 1'b1);
    vecs[4]  = mk(1'b0, 6'b011111, 1'b1, 1'b0, 1'b1, 1'b1);
    vecs[5]  = mk(1'b0, 6'b111110, 1'b1, 1'b0, 1'b1, 1'b1);
    vecs[6]  = mk(1'b0, 6'b111101, 1'b1, 1'b0, 1'b1, 1'b1);
    vecs[7]  = mk(1'b0, 6'b111011, 1'b1, 1'b0, 1'b1, 1'b1);
    vecs[8]  = mk(1'b0, 6'b110111, 1'b0, 1'b1, 1'b1, 1'b1);
    vecs[9]  = mk(1'b0, 6'b101111, 1'b0, 1'b1, 1'b1, 1'b1);
    vecs[10] = mk(1'b0, 6'b011110, 1'b0, 1'b1, 1'b1, 1'b1);
    vecs[11] = mk(1'b0, 6'b111100, 1'b0, 1'b1, 1'b1, 1'b1);
    vecs[12] = mk(1'b0, 6'b111001, 1'b0, 1'b0, 1'b1, 1'b1);
    vecs[13] = mk(1'b0, 6'b110011, 1'b0, 1'b0, 1'b1, 1'b1);
    vecs[14] = mk(1'b0, 6'b100111, 1'b0, 1'b0, 1'b1, 1'b1);
    vecs[15] = mk(1'b0, 6'b001110, 1'b0, 1'b0, 1'b1, 1'b1);
    vecs[16] = mk(1'b0, 6'b011101, 1'b0, 1'b0, 1'b0, 1'b1);
    vecs[17] = mk(1'b1, 6'b111010, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[18] = mk(1'b0, 6'b110101, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[19] = mk(1'b0, 6'b101011, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    check_reset_state("reset");
    exp_h = 6'b000000; exp_idx = 0; exp_ls = 1'b0;

    // Free-running lines: table, then reference for the remaining clocks
    for (int i = 0; i < 20; i++) begin
      cyc(vecs[i].tick, vecs[i].rsync, vecs[i].wsync, vecs[i].hmove);
      check6($sformatf("tbl%0d_hcount", i + 1), hcount, vecs[i].hc);
      check1($sformatf("tbl%0d_line_start", i + 1), line_start, vecs[i].ls);
      check1($sformatf("tbl%0d_hsync", i + 1), hsync, vecs[i].hs);
      check1($sformatf("tbl%0d_cburst", i + 1), cburst, vecs[i].cb);
      check1($sformatf("tbl%0d_hblank", i + 1), hblank, vecs[i].hb);
      check1($sformatf("tbl%0d_rdy", i + 1), rdy, vecs[i].rd);
    end
    exp_h = 6'b101011; exp_idx = 20; exp_ls = 1'b0;
    ls_count = 0;
    for (int c = 21; c <= 118; c++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      model_adv(1'b0);
      check_model(REL_NORM);
      if (line_start) ls_count++;
      if (c == 58) check1("wsync_held_to_line_end", rdy, 1'b0);
      if (c == 59) check1("wsync_release_at_line_start", rdy, 1'b1);
    end
    check_int("line_start_count_118clk", ls_count, 2);

    // RSYNC at index 30 restarts on that tick; next line is full length
    run(30, REL_NORM);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    model_adv(1'b1);
    check_model(REL_NORM);
    check1("rsync_line_start", line_start, 1'b1);
    run(58, REL_NORM);
    check6("rsync_full_line_last", hcount, 6'b101010);
    run(1, REL_NORM);
    check1("rsync_next_line_start", line_start, 1'b1);

    // WSYNC mid-line, repeated WSYNC, WSYNC during the line_start clock
    run(20, REL_NORM);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    model_adv(1'b0);
    check_model(REL_NORM);
    check1("wsync_drop_idx21", rdy, 1'b0);
    run(9, REL_NORM);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    model_adv(1'b0);
    check1("wsync_repeat_idx31", rdy, 1'b0);
    run(27, REL_NORM);
    check1("wsync_hold_idx58", rdy, 1'b0);
    run(1, REL_NORM);
    check1("wsync_release_ls", rdy, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    model_adv(1'b0);
    check1("wsync_on_ls_drop", rdy, 1'b0);
    run(57, REL_NORM);
    check1("wsync_on_ls_hold_idx58", rdy, 1'b0);
    run(1, REL_NORM);
    check1("wsync_on_ls_release", rdy, 1'b1);

    // HMOVE early in a line (current line), then a line without HMOVE
    run(2, REL_NORM);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    model_adv(1'b0);
    check_model(REL_LATE);
    run(55, REL_LATE);
    run(1, REL_NORM);
    run(59, REL_NORM);
    // HMOVE late in a line applies to the following line only
    run(30, REL_NORM);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    model_adv(1'b0);
    check_model(REL_NORM);
    run(28, REL_NORM);
    run(59, REL_LATE);
    run(59, REL_NORM);

    // tick low for 10 clocks mid-line; WSYNC in the gap still drops rdy
    run(25, REL_NORM);
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 1'b0, (k == 3), 1'b0);
      model_hold();
      check_model(REL_NORM);
      if (k >= 3) check1($sformatf("gap_wsync_rdy_%0d", k), rdy, 1'b0);
    end
    run(33, REL_NORM);
    run(1, REL_NORM);
    check1("gap_wsync_release", rdy, 1'b1);

    // Reset at index 40 with rdy low and an rsync pending
    run(40, REL_NORM);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check1("pre_reset_rdy_low", rdy, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    model_hold();
    check_model(REL_NORM);
    reset = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    check_reset_state("midline_reset");
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check6("post_reset_rsync_discarded", hcount, 6'b000001);
    check1("post_reset_no_line_start", line_start, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
